// File: rtl/sti_cmd_feeder.sv
`timescale 1ns/1ps
// Command feeder for the STI/DAC serializer: queues parallel commands, presents one word per serial burst.
// Latency: load is high in the cycle after the edge that follows a push into an empty FIFO while idle.
// Backpressure: cmd_ready low when the FIFO is full, after the last command is accepted, or once in DONE.
module sti_cmd_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic [1:0]  cmd_length,
    input  logic        cmd_fill,
    input  logic        cmd_msb,
    input  logic        cmd_low,
    input  logic        cmd_last,
    input  logic        so_valid,
    output logic        load,
    output logic [15:0] pi_data,
    output logic [1:0]  pi_length,
    output logic        pi_fill,
    output logic        pi_msb,
    output logic        pi_low,
    output logic        pi_end,
    output logic        busy,
    output logic        len_err,
    output logic        timeout_err
);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYCLES - 1);

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  length;
        logic        fill;
        logic        msb;
        logic        low;
        logic        last;
    } cmd_ent_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_SV,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    cmd_ent_t      r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_last_acc;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    cmd_ent_t      w_in;
    cmd_ent_t      w_head;

    logic [15:0]   r_pi_data;
    logic [1:0]    r_pi_length;
    logic          r_pi_fill;
    logic          r_pi_msb;
    logic          r_pi_low;
    logic          r_pi_end;
    logic          r_len_err;
    logic          r_timeout_err;
    logic [7:0]    r_wait_cnt;
    logic [7:0]    w_wait_nxt;
    logic [5:0]    r_bit_cnt;
    logic [5:0]    w_exp_bits;
    logic [3:0]    r_gap_cnt;

    assign w_in       = '{data: cmd_data, length: cmd_length, fill: cmd_fill,
                          msb: cmd_msb, low: cmd_low, last: cmd_last};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_full     = (r_count == DEPTH_L);
    assign w_empty    = (r_count == '0);
    // Held low while reset is asserted so every output reads 0 during reset.
    assign cmd_ready  = !w_full && !r_last_acc && (r_state != S_DONE) && !reset;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_wait_nxt = r_wait_cnt + 8'd1;
    // Expected burst length 8*(length+1): 8, 16, 24 or 32 bits.
    assign w_exp_bits = {({1'b0, r_pi_length} + 3'd1), 3'b000};

    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign pi_data     = r_pi_data;
    assign pi_length   = r_pi_length;
    assign pi_fill     = r_pi_fill;
    assign pi_msb      = r_pi_msb;
    assign pi_low      = r_pi_low;
    assign pi_end      = r_pi_end;
    assign len_err     = r_len_err;
    assign timeout_err = r_timeout_err;

    // FIFO storage; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // FIFO pointers, occupancy and the end-of-stream acceptance flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_acc <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (cmd_last) begin
                    r_last_acc <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, FIFO pop and the load strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        load        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load        = 1'b1;
                w_state_nxt = S_WAIT_SV;
            end
            S_WAIT_SV: begin
                if (so_valid) begin
                    w_state_nxt = S_SHIFT;
                end else if (w_wait_nxt == TIMEOUT_L) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SHIFT: begin
                if (!so_valid) begin
                    if (r_pi_end) begin
                        w_state_nxt = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Held pi_* fields, burst counters and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pi_data     <= '0;
            r_pi_length   <= '0;
            r_pi_fill     <= 1'b0;
            r_pi_msb      <= 1'b0;
            r_pi_low      <= 1'b0;
            r_pi_end      <= 1'b0;
            r_len_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wait_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_pi_data   <= w_head.data;
                        r_pi_length <= w_head.length;
                        r_pi_fill   <= w_head.fill;
                        r_pi_msb    <= w_head.msb;
                        r_pi_low    <= w_head.low;
                        r_pi_end    <= w_head.last;
                    end
                end
                S_LOAD: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT_SV: begin
                    r_wait_cnt <= w_wait_nxt;
                    if (so_valid) begin
                        r_bit_cnt <= 6'd1;
                    end else if (w_wait_nxt == TIMEOUT_L) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (so_valid) begin
                        if (r_bit_cnt != 6'h3F) begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end else begin
                        if (r_bit_cnt != w_exp_bits) begin
                            r_len_err <= 1'b1;
                        end
                        r_gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sti_cmd_feeder.sv
`timescale 1ns/1ps
// Bench for sti_cmd_feeder: random command streams against a queue-based reference and a serializer model.
// Latency: checks the push-to-load timing, burst-to-load gap and timeout cycle.
// Backpressure: exercises FIFO-full, end-of-stream and DONE gating of cmd_ready.
module tb_sti_cmd_feeder;
    localparam int GAP = 1;
    localparam int TMO = 63;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  len;
        logic        fill;
        logic        msb;
        logic        low;
        logic        last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_length;
    logic        cmd_fill;
    logic        cmd_msb;
    logic        cmd_low;
    logic        cmd_last;
    logic        so_valid;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        busy;
    logic        len_err;
    logic        timeout_err;

    sti_cmd_feeder #(.FIFO_DEPTH(4), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_length(cmd_length), .cmd_fill(cmd_fill), .cmd_msb(cmd_msb),
        .cmd_low(cmd_low), .cmd_last(cmd_last), .so_valid(so_valid),
        .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
        .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .busy(busy),
        .len_err(len_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [26:0] w_outs   = {load, busy, cmd_ready, pi_data, pi_length, pi_fill,
                            pi_msb, pi_low, pi_end, len_err, timeout_err};
    wire [21:0] w_pi_all = {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end};

    int   errors = 0;
    int   checks = 0;

    // Reference state: words expected at the next loads, per-burst length plans, sticky error model.
    cmd_t exp_q[$];
    int   plan_q[$];
    int   load_cycs[$];
    int   n_loads = 0;
    bit   exp_len_err = 1'b0;
    int   epoch = 0;
    int   last_fall = -1000;
    int   ser_fix_delay = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] len, input logic last);
        cmd_t c;
        c.data = 16'($urandom);
        c.len  = len;
        c.fill = 1'($urandom_range(0, 1));
        c.msb  = 1'($urandom_range(0, 1));
        c.low  = 1'($urandom_range(0, 1));
        c.last = last;
        return c;
    endfunction

    // Serializer model: on each load, compare the presented word with the queue head,
    // then play a burst of the planned length and check stability and the length flag.
    initial begin : ser_model
        cmd_t e;
        int   n;
        int   d;
        int   p;
        int   my_ep;
        bit   unstable;
        bit   aborted;
        logic [21:0] snap;
        so_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (load !== 1'b1) continue;
            my_ep = epoch;
            n_loads++;
            load_cycs.push_back(cyc);
            chk("gap_before_load", 32'(cyc - last_fall >= GAP + 1), 1);
            chk("load_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("pi_data", pi_data, e.data);
            chk("pi_length", pi_length, e.len);
            chk("pi_flags", {pi_fill, pi_msb, pi_low}, {e.fill, e.msb, e.low});
            chk("pi_end", pi_end, e.last);
            snap = w_pi_all;
            n = 8 * (int'(e.len) + 1);
            if (plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p >= 0) n = p;
            end
            if (n == 0) continue;
            d = (ser_fix_delay > 0) ? ser_fix_delay : int'($urandom_range(1, 5));
            unstable = 1'b0;
            aborted  = 1'b0;
            for (int i = 0; i < d && !aborted; i++) begin
                @(posedge clk); #1;
                if (epoch != my_ep) aborted = 1'b1;
                else if (w_pi_all !== snap) unstable = 1'b1;
            end
            if (!aborted) so_valid = 1'b1;
            for (int i = 0; i < n && !aborted; i++) begin
                @(posedge clk); #1;
                if (epoch != my_ep) aborted = 1'b1;
                else if (w_pi_all !== snap) unstable = 1'b1;
            end
            so_valid = 1'b0;
            if (aborted) continue;
            last_fall = cyc;
            exp_len_err = exp_len_err | (n != 8 * (int'(e.len) + 1));
            @(posedge clk); #1;
            if (epoch == my_ep) begin
                chk("pi_stable", {31'd0, unstable}, 0);
                chk("len_err", len_err, exp_len_err);
                if (e.last) begin
                    chk("done_busy", busy, 0);
                    chk("done_ready", cmd_ready, 0);
                end
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        epoch++;
        cmd_valid = 1'b0;
        #1;
        chk("rst_async_outs", w_outs, 0);
        @(posedge clk); #1;
        chk("rst_outs", w_outs, 0);
        @(posedge clk); #1;
        exp_q.delete();
        plan_q.delete();
        load_cycs.delete();
        n_loads       = 0;
        exp_len_err   = 1'b0;
        last_fall     = -1000;
        ser_fix_delay = 0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 1);
    endtask

    task automatic push(input cmd_t c, output int acc_cyc);
        int guard;
        guard      = 0;
        cmd_valid  = 1'b1;
        cmd_data   = c.data;
        cmd_length = c.len;
        cmd_fill   = c.fill;
        cmd_msb    = c.msb;
        cmd_low    = c.low;
        cmd_last   = c.last;
        do begin
            @(negedge clk);
            guard++;
        end while (!cmd_ready && guard < 400);
        if (!cmd_ready) chk("push_accept", cmd_ready, 1);
        @(posedge clk); #1;
        exp_q.push_back(c);
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k;
        k = 0;
        while (!(!busy && (pi_end || timeout_err)) && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_reached", {busy, pi_end | timeout_err}, 2'b01);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_burst(input string tag);
        int k;
        k = 0;
        while (!so_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, so_valid, 1);
    endtask

    initial begin : main
        cmd_t c;
        int   a;
        int   acc[5];
        int   lc;
        int   k;
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_length = '0;
        cmd_fill = 1'b0; cmd_msb = 1'b0; cmd_low = 1'b0; cmd_last = 1'b0;

        // Single 8-bit word, low byte select, end of stream.
        do_reset();
        ser_fix_delay = 3;
        c = '{data: 16'hA55A, len: 2'b00, fill: 1'b0, msb: 1'b0, low: 1'b1, last: 1'b1};
        push(c, a);
        chk("a_lat_edge1", load, 0);
        @(posedge clk); #1;
        chk("a_lat_edge2", load, 1);
        wait_done(200);
        chk("a_loads", n_loads, 1);
        chk("a_pi_data", pi_data, 16'hA55A);
        chk("a_pi_low", pi_low, 1);
        chk("a_pi_end", pi_end, 1);
        chk("a_errs", {len_err, timeout_err}, 0);

        // Four words of increasing length, last on the fourth.
        do_reset();
        for (int i = 0; i < 4; i++) push(mk(2'(i), i == 3), a);
        wait_done(600);
        chk("b_loads", n_loads, 4);
        chk("b_errs", {len_err, timeout_err}, 0);

        // FIFO full while the serializer holds a long burst.
        do_reset();
        plan_q.push_back(40);
        push(mk(2'b00, 1'b0), a);
        wait_burst("c_burst_started");
        for (int i = 0; i < 4; i++) push(mk(2'($urandom_range(0, 3)), 1'b0), acc[i]);
        chk("c_full_ready", cmd_ready, 0);
        chk("c_back_to_back", acc[3] - acc[0], 3);
        push(mk(2'($urandom_range(0, 3)), 1'b1), acc[4]);
        chk("c_5th_after_pop", 32'((load_cycs.size() >= 2) && (acc[4] > load_cycs[1])), 1);
        wait_done(800);
        chk("c_loads", n_loads, 6);
        chk("c_len_err", len_err, 1);

        // Short burst on a 16-bit word flags len_err; the stream continues.
        do_reset();
        plan_q.push_back(15);
        plan_q.push_back(-1);
        push(mk(2'b01, 1'b0), a);
        push(mk(2'($urandom_range(0, 3)), 1'b1), a);
        wait_done(400);
        chk("d_len_err", len_err, 1);
        chk("d_loads", n_loads, 2);

        // Serializer never answers: timeout ends the stream in DONE.
        do_reset();
        plan_q.push_back(0);
        push(mk(2'b10, 1'b0), a);
        push(mk(2'b11, 1'b0), a);
        k = 0;
        while (load_cycs.size() == 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("e_loaded", load_cycs.size(), 1);
        lc = (load_cycs.size() > 0) ? load_cycs[0] : cyc;
        while (cyc < lc + TMO) begin
            @(posedge clk); #1;
        end
        chk("e_to_before", {busy, timeout_err}, 2'b10);
        @(posedge clk); #1;
        chk("e_timeout", timeout_err, 1);
        chk("e_done_busy", busy, 0);
        chk("e_done_ready", cmd_ready, 0);
        chk("e_pi_end", pi_end, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("e_loads", n_loads, 1);
        chk("e_len_err", len_err, 0);

        // Reset in the middle of a burst with three words queued.
        do_reset();
        plan_q.push_back(30);
        for (int i = 0; i < 4; i++) push(mk(2'($urandom_range(0, 3)), 1'b0), a);
        wait_burst("f_burst_started");
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("f_no_load", n_loads, 0);
        chk("f_idle", busy, 0);
        push(mk(2'b01, 1'b1), a);
        chk("f_lat_edge1", load, 0);
        @(posedge clk); #1;
        chk("f_lat_edge2", load, 1);
        wait_done(300);
        chk("f_loads", n_loads, 1);

        // Random stream of eight words with occasional length mismatches.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            c = mk(2'($urandom_range(0, 3)), i == 7);
            if ($urandom_range(0, 3) == 0)
                plan_q.push_back(8 * (int'(c.len) + 1) + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(1, 3)));
            else
                plan_q.push_back(-1);
            push(c, a);
        end
        wait_done(1500);
        chk("g_loads", n_loads, 8);
        chk("g_timeout", timeout_err, 0);
        chk("g_len_err", len_err, exp_len_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
